isolde_vlen_instr_assembler: RTL and testbench
==============================================

Name: isolde_vlen_instr_assembler

Overview:
- Sits between the instruction fetch FIFO and the ISOLDE opcode decoder.
- Takes the 32-bit fetch word stream and reads the length encoding in the first word: opcode [6:0], nnn [14:12].
- Gathers 1, 2, 3 or 5 consecutive words into one left-aligned instruction bundle and presents it with its word count and start address.
- Flags illegal length encodings and fetch errors, and supports pipeline flush.

Parameters:
- MaxWords, 5, maximum instruction length in 32-bit words; sets the width of instr_data_o.
- AddrWidth, 32, width of the fetch address.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  discard any partial or held instruction (branch/exception)
- fetch_valid_i  input  1  fetch word valid
- fetch_ready_o  output  1  assembler accepts the fetch word
- fetch_rdata_i  input  32  fetch word
- fetch_addr_i  input  AddrWidth  byte address of the fetch word
- fetch_err_i  input  1  bus error on this fetch word
- instr_valid_o  output  1  assembled instruction valid
- instr_ready_i  input  1  decoder consumes the instruction
- instr_data_o  output  32*MaxWords  word k at bits [32k+31:32k]; unused words are zero
- instr_addr_o  output  AddrWidth  address of word 0
- instr_words_o  output  3  number of words held (1..MaxWords)
- instr_illegal_o  output  1  illegal length encoding
- instr_fetch_err_o  output  1  a word of this instruction carried fetch_err_i

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State IDLE.
  - instr_valid_o, instr_illegal_o and instr_fetch_err_o are 0.
  - instr_data_o and instr_addr_o are 0; instr_words_o is 0.
  - Word counter and target length are 0.
- Handshake: a word transfers when fetch_valid_i && fetch_ready_o. An instruction transfers when instr_valid_o && instr_ready_i.
- Target length, computed from the first word only:
  - opcode 7'h7F with nnn 3'h5 gives 5.
  - opcode 7'h7F with nnn 3'h1 gives 3.
  - opcode 7'h7F with any other nnn gives 1, and instr_illegal_o is set.
  - opcode 7'h3F gives 2.
  - Every other opcode (including 7'h0B and 7'h2B) gives 1.
  - func7 is not examined.
- FSM states and transitions:
  - IDLE: fetch_ready_o=1. A first-word transfer captures the word into slot 0, records its address, sets target and count=1, and latches err/illegal. If target==1 (or fetch_err_i is set), go to DONE; otherwise go to COLLECT.
  - COLLECT: fetch_ready_o=1. Each transfer writes slot[count] and increments count. Go to DONE when count+1==target or when fetch_err_i=1 (early termination; instr_words_o = words received, instr_fetch_err_o=1).
  - DONE: instr_valid_o=1 and all outputs are stable until the transfer. fetch_ready_o=instr_ready_i.
    - Transfer with a simultaneous first-word transfer: load the new instruction directly (back-to-back, no bubble).
    - Transfer without one: go to IDLE and clear data to zero.
- Latency and throughput:
  - instr_valid_o rises the cycle after the final word transfers (registered output).
  - Throughput is one word per cycle. Sustained 1-word instructions complete one per cycle.
- Addresses: fetch_addr_i is only sampled on the first word. Subsequent words are not address-checked.
- Flush: flush_i=1 takes priority over everything.
  - fetch_ready_o=0 in that cycle.
  - Next state is IDLE, with the counter cleared and instr_valid_o=0.
  - A held DONE instruction is dropped even if instr_ready_i=1.
- Widths: the counter is 3 bits. Only words 0..MaxWords-1 are written; count never exceeds target.
- Illegal-encoding instructions are emitted as 1-word instructions. The decoder is responsible for raising the exception.

Test Plan:
- Single word: reset, then word 0x0000100B at addr 0x80 with instr_ready_i=1 → next cycle instr_valid_o=1, words=1, data[31:0]=0x0000100B, addr=0x80, illegal=0.
- Five-word with gaps and backpressure:
  - Stimulus: 0x0000507F then 0x11111111, 0x22222222, 0x33333333, 0x44444444, with fetch_valid_i low for 2 cycles between words 2 and 3; instr_ready_i held low for 3 cycles.
  - Required: words=5 with data in slots 0..4, outputs stable while stalled, and fetch_ready_o=0 during the stall.
- Length table:
  - 0x0E00003F, 0xAAAAAAAA → words=2.
  - 0x0000107F plus 2 words → words=3.
  - 0x0000207F → words=1, illegal=1.
- Fetch error: 0x0000507F, then the 2nd word with fetch_err_i=1 → emitted with words=2, instr_fetch_err_o=1, slots 2..4 zero.
- Flush: flush_i pulsed after 2 of 3 words of a 0x0000107F instruction → no instr_valid_o. A following 0x0000100B is emitted alone with words=1.
- Back-to-back: continuous 1-word stream 0x0000100B, 0x0000102B, 0x00001033 with instr_ready_i=1 → three consecutive valid cycles and no bubbles.

Source files
------------

// File: rtl/isolde_vlen_instr_assembler.sv
// isolde_vlen_instr_assembler
//   Gathers 1, 2, 3 or 5 consecutive 32-bit fetch words into one left-aligned
//   instruction bundle for the ISOLDE decoder. The length comes from the
//   first word: opcode [6:0] and nnn [14:12].
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop any partial or held instruction
//   fetch_*                word stream from the fetch FIFO (valid/ready)
//   instr_*                assembled instruction to the decoder (valid/ready)
//     instr_data_o         word k at bits [32k+31:32k], unused words zero
//     instr_words_o        words held (1..MaxWords)
//     instr_illegal_o      illegal length encoding (emitted as 1 word)
//     instr_fetch_err_o    one of the words carried a fetch error
module isolde_vlen_instr_assembler #(
  parameter int unsigned MaxWords  = 5,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [31:0]            fetch_rdata_i,
  input  logic [AddrWidth-1:0]   fetch_addr_i,
  input  logic                   fetch_err_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [32*MaxWords-1:0] instr_data_o,
  output logic [AddrWidth-1:0]   instr_addr_o,
  output logic [2:0]             instr_words_o,
  output logic                   instr_illegal_o,
  output logic                   instr_fetch_err_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [2:0]                 tgt_q, tgt_d;
  logic [MaxWords-1:0][31:0]  data_q, data_d;
  logic [AddrWidth-1:0]       addr_q, addr_d;
  logic                       err_q, err_d;
  logic                       ill_q, ill_d;

  // Length decode of the incoming word, used only when it is a first word.
  logic [6:0] opc;
  logic [2:0] nnn;
  logic [2:0] first_tgt;
  logic       first_ill;

  assign opc = fetch_rdata_i[6:0];
  assign nnn = fetch_rdata_i[14:12];

  always_comb begin
    first_tgt = 3'd1;
    first_ill = 1'b0;
    if (opc == 7'h7F) begin
      if (nnn == 3'h5)      first_tgt = 3'd5;
      else if (nnn == 3'h1) first_tgt = 3'd3;
      else                  first_ill = 1'b1;
    end else if (opc == 7'h3F) begin
      first_tgt = 3'd2;
    end
  end

  logic load_first;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    data_d        = data_q;
    addr_d        = addr_q;
    err_d         = err_q;
    ill_d         = ill_q;
    fetch_ready_o = 1'b0;
    load_first    = 1'b0;

    if (flush_i) begin
      // Flush wins: nothing is accepted and a held instruction is dropped.
      state_d = IDLE;
      cnt_d   = '0;
      tgt_d   = '0;
      data_d  = '0;
      addr_d  = '0;
      err_d   = 1'b0;
      ill_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          fetch_ready_o = 1'b1;
          load_first    = fetch_valid_i;
        end
        COLLECT: begin
          fetch_ready_o = 1'b1;
          if (fetch_valid_i) begin
            if (cnt_q < 3'(MaxWords)) data_d[cnt_q] = fetch_rdata_i;
            cnt_d = cnt_q + 3'd1;
            err_d = err_q | fetch_err_i;
            // A bad word ends the instruction early with what we have.
            if (fetch_err_i || (cnt_q + 3'd1 == tgt_q)) state_d = DONE;
          end
        end
        DONE: begin
          // Accepting a new word is only safe when the held one leaves now.
          fetch_ready_o = instr_ready_i;
          if (instr_ready_i) begin
            if (fetch_valid_i) begin
              load_first = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              tgt_d   = '0;
              data_d  = '0;
              addr_d  = '0;
              err_d   = 1'b0;
              ill_d   = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load_first) begin
        // Clearing first keeps the unused upper slots zero.
        data_d    = '0;
        data_d[0] = fetch_rdata_i;
        addr_d    = fetch_addr_i;
        tgt_d     = first_tgt;
        cnt_d     = 3'd1;
        err_d     = fetch_err_i;
        ill_d     = first_ill;
        state_d   = (first_tgt == 3'd1 || fetch_err_i) ? DONE : COLLECT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
    end
  end

  assign instr_valid_o     = (state_q == DONE);
  assign instr_data_o      = data_q;
  assign instr_addr_o      = addr_q;
  assign instr_words_o     = cnt_q;
  assign instr_illegal_o   = ill_q;
  assign instr_fetch_err_o = err_q;

endmodule

// File: tb/tb_isolde_vlen_instr_assembler.sv
module tb_isolde_vlen_instr_assembler;
  localparam int MW = 5;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          fvalid;
  logic          fready;
  logic [31:0]   frdata;
  logic [AW-1:0] faddr;
  logic          ferr;
  logic          ivalid;
  logic          iready;
  logic [32*MW-1:0] idata;
  logic [AW-1:0] iaddr;
  logic [2:0]    iwords;
  logic          iill;
  logic          iferr;

  int checks = 0;
  int errors = 0;

  isolde_vlen_instr_assembler #(.MaxWords(MW), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .fetch_valid_i(fvalid), .fetch_ready_o(fready), .fetch_rdata_i(frdata),
    .fetch_addr_i(faddr), .fetch_err_i(ferr),
    .instr_valid_o(ivalid), .instr_ready_i(iready), .instr_data_o(idata),
    .instr_addr_o(iaddr), .instr_words_o(iwords),
    .instr_illegal_o(iill), .instr_fetch_err_o(iferr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one cycle (assembler is ready in IDLE/COLLECT).
  task automatic send(input logic [31:0] w, input logic [AW-1:0] a, input logic e);
    fvalid = 1'b1; frdata = w; faddr = a; ferr = e;
    tick();
    fvalid = 1'b0; ferr = 1'b0;
  endtask

  task automatic drain();
    iready = 1'b1;
    tick();
    iready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; fvalid = 0; frdata = '0; faddr = '0; ferr = 0; iready = 0;
    #12;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ivalid); end
    checks++; if (idata !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", idata); end
    checks++; if (iaddr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", iaddr); end
    checks++; if (iwords !== 3'd0) begin errors++; $display("FAIL reset_words got %0d exp 0", iwords); end
    checks++; if (iill !== 1'b0 || iferr !== 1'b0) begin errors++; $display("FAIL reset_flags got ill=%b err=%b exp 0 0", iill, iferr); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (fready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fready); end
  endtask

  task automatic test_single();
    iready = 1'b1;
    send(32'h0000100B, 32'h80, 1'b0);
    checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ivalid); end
    checks++; if (iwords !== 3'd1) begin errors++; $display("FAIL single_words got %0d exp 1", iwords); end
    checks++; if (idata !== {128'h0, 32'h0000100B}) begin errors++; $display("FAIL single_data got %h exp 100b", idata); end
    checks++; if (iaddr !== 32'h80) begin errors++; $display("FAIL single_addr got %h exp 80", iaddr); end
    checks++; if (iill !== 1'b0) begin errors++; $display("FAIL single_illegal got %b exp 0", iill); end
    tick();
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL single_consumed got %b exp 0", ivalid); end
    iready = 1'b0;
  endtask

  task automatic test_five();
    logic [32*MW-1:0] exp;
    exp = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h0000507F};
    iready = 1'b0;
    send(32'h0000507F, 32'h100, 1'b0);
    send(32'h11111111, 32'h104, 1'b0);
    send(32'h22222222, 32'h108, 1'b0);
    tick(); tick();
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL five_early_valid got %b exp 0", ivalid); end
    send(32'h33333333, 32'h10C, 1'b0);
    send(32'h44444444, 32'h110, 1'b0);
    // Offer another word while the decoder stalls; it must not be taken.
    fvalid = 1'b1; frdata = 32'h0000100B; faddr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ivalid !== 1'b1 || iwords !== 3'd5 || idata !== exp || iaddr !== 32'h100)
        begin errors++; $display("FAIL five_hold%0d got v=%b w=%0d a=%h d=%h exp 1 5 100 %h", i, ivalid, iwords, iaddr, idata, exp); end
      checks++; if (fready !== 1'b0) begin errors++; $display("FAIL five_stall_ready%0d got %b exp 0", i, fready); end
      tick();
    end
    fvalid = 1'b0;
    drain();
    checks++; if (ivalid !== 1'b0 || idata !== '0) begin errors++; $display("FAIL five_drain got v=%b d=%h exp 0 0", ivalid, idata); end
  endtask

  task automatic test_lengths();
    iready = 1'b0;
    send(32'h0E00003F, 32'h300, 1'b0);
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL len2_early got %b exp 0", ivalid); end
    send(32'hAAAAAAAA, 32'h304, 1'b0);
    checks++; if (ivalid !== 1'b1 || iwords !== 3'd2 || idata !== {96'h0, 32'hAAAAAAAA, 32'h0E00003F})
      begin errors++; $display("FAIL len2 got v=%b w=%0d d=%h exp 1 2", ivalid, iwords, idata); end
    drain();
    send(32'h0000107F, 32'h400, 1'b0);
    send(32'h01010101, 32'h404, 1'b0);
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL len3_early got %b exp 0", ivalid); end
    send(32'h02020202, 32'h408, 1'b0);
    checks++; if (ivalid !== 1'b1 || iwords !== 3'd3 || iill !== 1'b0 || idata !== {64'h0, 32'h02020202, 32'h01010101, 32'h0000107F})
      begin errors++; $display("FAIL len3 got v=%b w=%0d ill=%b d=%h exp 1 3 0", ivalid, iwords, iill, idata); end
    drain();
    send(32'h0000207F, 32'h500, 1'b0);
    checks++; if (ivalid !== 1'b1 || iwords !== 3'd1 || iill !== 1'b1 || iaddr !== 32'h500)
      begin errors++; $display("FAIL len_illegal got v=%b w=%0d ill=%b a=%h exp 1 1 1 500", ivalid, iwords, iill, iaddr); end
    drain();
    checks++; if (iill !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b exp 0", iill); end
  endtask

  task automatic test_fetch_err();
    iready = 1'b0;
    send(32'h0000507F, 32'h600, 1'b0);
    send(32'h55555555, 32'h604, 1'b1);
    checks++; if (ivalid !== 1'b1 || iwords !== 3'd2 || iferr !== 1'b1)
      begin errors++; $display("FAIL ferr got v=%b w=%0d err=%b exp 1 2 1", ivalid, iwords, iferr); end
    checks++; if (idata !== {96'h0, 32'h55555555, 32'h0000507F})
      begin errors++; $display("FAIL ferr_data got %h", idata); end
    drain();
    checks++; if (ivalid !== 1'b0 || iferr !== 1'b0) begin errors++; $display("FAIL ferr_drain got v=%b err=%b exp 0 0", ivalid, iferr); end
  endtask

  task automatic test_flush();
    iready = 1'b0;
    send(32'h0000107F, 32'h700, 1'b0);
    send(32'h0A0A0A0A, 32'h704, 1'b0);
    flush = 1'b1; fvalid = 1'b1; frdata = 32'h0B0B0B0B;
    #1;
    checks++; if (fready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", fready); end
    tick();
    flush = 1'b0; fvalid = 1'b0;
    tick();
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ivalid); end
    send(32'h0000100B, 32'h800, 1'b0);
    checks++; if (ivalid !== 1'b1 || iwords !== 3'd1 || idata !== {128'h0, 32'h0000100B} || iaddr !== 32'h800)
      begin errors++; $display("FAIL flush_after got v=%b w=%0d a=%h d=%h exp 1 1 800", ivalid, iwords, iaddr, idata); end
    // A held instruction is dropped by flush even with the decoder ready.
    flush = 1'b1; iready = 1'b1;
    tick();
    flush = 1'b0; iready = 1'b0;
    checks++; if (ivalid !== 1'b0 || iwords !== 3'd0) begin errors++; $display("FAIL flush_done got v=%b w=%0d exp 0 0", ivalid, iwords); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ws [3];
    ws[0] = 32'h0000100B; ws[1] = 32'h0000102B; ws[2] = 32'h00001033;
    iready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fvalid = 1'b1; frdata = ws[i]; faddr = 32'h900 + 32'(4 * i);
      #1;
      checks++; if (fready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, fready); end
      tick();
      checks++; if (ivalid !== 1'b1 || iwords !== 3'd1 || idata !== {128'h0, ws[i]} || iaddr !== 32'h900 + 32'(4 * i))
        begin errors++; $display("FAIL b2b%0d got v=%b w=%0d a=%h d=%h exp %h", i, ivalid, iwords, iaddr, idata, ws[i]); end
    end
    fvalid = 1'b0;
    tick();
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", ivalid); end
    iready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_five();
    test_lengths();
    test_fetch_err();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
